// File: rtl/bram_port_arbiter_pkg.sv
// Shared widths and packed-bus helpers for the block-RAM port arbiter.
// Requester i of a packed bus occupies bits [i*w +: w].
`define BPA_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package bram_port_arbiter_pkg;

   // Index width that never collapses to zero bits, so one requester still has a legal id.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from req and a registered priority pointer.
// The pointer moves one past the last winner; it holds when nothing is granted.
module rr_arbiter
   import bram_port_arbiter_pkg::*;
#(
   parameter int N = 2,
   localparam int IDW = clog2_min1(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_idx
);

   logic [IDW-1:0] ptr_r;
   logic [IDW-1:0] ptr_next_s;
   logic [IDW-1:0] idx_s;
   logic [IDW-1:0] cand_s;
   logic [N-1:0]   gnt_s;
   logic           found_s;
   logic           hit_s;

   // Scan from the pointer and keep the first requester seen.
   always_comb begin
      gnt_s   = '0;
      idx_s   = '0;
      found_s = 1'b0;
      hit_s   = 1'b0;
      cand_s  = '0;
      for (int k = 0; k < N; k++) begin
         cand_s         = IDW'((int'(ptr_r) + k) % N);
         hit_s          = req[cand_s] & ~found_s;
         gnt_s[cand_s]  = gnt_s[cand_s] | hit_s;
         idx_s          = hit_s ? cand_s : idx_s;
         found_s        = found_s | hit_s;
      end
   end

   // Grants are suppressed while reset is held.
   always_comb begin
      gnt        = rst ? '0 : gnt_s;
      gnt_idx    = idx_s;
      ptr_next_s = (int'(idx_s) == N - 1) ? '0 : idx_s + IDW'(1);
   end

   // Priority pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r <= '0;
      end else if (|gnt_s) begin
         ptr_r <= ptr_next_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple dual-port block RAM among several writers and readers.
// Write and read ports are arbitrated independently; read data returns one cycle after grant.
module bram_port_arbiter
   import bram_port_arbiter_pkg::*;
#(
   parameter int BRAM_WIDTH = 32,
   parameter int BRAM_DEPTH = 256,
   parameter int NUM_WR     = 2,
   parameter int NUM_RD     = 2,
   localparam int AW        = clog2_min1(BRAM_DEPTH),
   localparam int IDW       = clog2_min1(NUM_RD),
   localparam int WIDW      = clog2_min1(NUM_WR)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_WR-1:0]            wr_req,
   input  logic [NUM_WR*AW-1:0]         wr_addr,
   input  logic [NUM_WR*BRAM_WIDTH-1:0] wr_data,
   output logic [NUM_WR-1:0]            wr_gnt,
   input  logic [NUM_RD-1:0]            rd_req,
   input  logic [NUM_RD*AW-1:0]         rd_addr,
   output logic [NUM_RD-1:0]            rd_gnt,
   output logic                         rd_valid,
   output logic [IDW-1:0]               rd_id,
   output logic [BRAM_WIDTH-1:0]        rd_data,
   output logic                         bram_we,
   output logic [AW-1:0]                bram_addrin,
   output logic [BRAM_WIDTH-1:0]        bram_din,
   output logic                         bram_re,
   output logic [AW-1:0]                bram_addrout,
   input  logic [BRAM_WIDTH-1:0]        bram_dout
);

   logic [NUM_WR-1:0] wr_gnt_s;
   logic [WIDW-1:0]   wr_idx_s;
   logic [NUM_RD-1:0] rd_gnt_s;
   logic [IDW-1:0]    rd_idx_s;
   logic              rd_valid_r;
   logic [IDW-1:0]    rd_id_r;

   rr_arbiter #(.N(NUM_WR)) u_wr_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (wr_req),
      .gnt     (wr_gnt_s),
      .gnt_idx (wr_idx_s)
   );

   rr_arbiter #(.N(NUM_RD)) u_rd_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (rd_req),
      .gnt     (rd_gnt_s),
      .gnt_idx (rd_idx_s)
   );

   // RAM port drive: winner's address/data, zero when the port is idle.
   always_comb begin
      wr_gnt       = wr_gnt_s;
      rd_gnt       = rd_gnt_s;
      bram_we      = |wr_gnt_s;
      bram_re      = |rd_gnt_s;
      bram_addrin  = '0;
      bram_din     = '0;
      bram_addrout = '0;
      if (bram_we) begin
         bram_addrin = `BPA_SLICE(wr_addr, wr_idx_s, AW);
         bram_din    = `BPA_SLICE(wr_data, wr_idx_s, BRAM_WIDTH);
      end else begin
         bram_addrin = '0;
         bram_din    = '0;
      end
      if (bram_re) begin
         bram_addrout = `BPA_SLICE(rd_addr, rd_idx_s, AW);
      end else begin
         bram_addrout = '0;
      end
   end

   // Response tag tracks the RAM's one-cycle read latency; reset drops an in-flight response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_r <= 1'b0;
         rd_id_r    <= '0;
      end else begin
         rd_valid_r <= bram_re;
         if (bram_re) begin
            rd_id_r <= rd_idx_s;
         end else begin
            rd_id_r <= rd_id_r;
         end
      end
   end

   always_comb begin
      rd_valid = rd_valid_r;
      rd_id    = rd_id_r;
      rd_data  = bram_dout;
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a behavioural write-first RAM behind it.
module tb_bram_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 8;

   logic          clk;
   logic          rst;
   logic [1:0]    wr_req;
   logic [15:0]   wr_addr;
   logic [63:0]   wr_data;
   logic [1:0]    wr_gnt;
   logic [1:0]    rd_req;
   logic [15:0]   rd_addr;
   logic [1:0]    rd_gnt;
   logic          rd_valid;
   logic [0:0]    rd_id;
   logic [DW-1:0] rd_data;
   logic          bram_we;
   logic [AW-1:0] bram_addrin;
   logic [DW-1:0] bram_din;
   logic          bram_re;
   logic [AW-1:0] bram_addrout;
   logic [DW-1:0] bram_dout;

   logic [AW-1:0] wa [2];
   logic [DW-1:0] wd [2];
   logic [AW-1:0] ra [2];

   assign wr_addr = {wa[1], wa[0]};
   assign wr_data = {wd[1], wd[0]};
   assign rd_addr = {ra[1], ra[0]};

   bram_port_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .wr_req       (wr_req),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_gnt       (wr_gnt),
      .rd_req       (rd_req),
      .rd_addr      (rd_addr),
      .rd_gnt       (rd_gnt),
      .rd_valid     (rd_valid),
      .rd_id        (rd_id),
      .rd_data      (rd_data),
      .bram_we      (bram_we),
      .bram_addrin  (bram_addrin),
      .bram_din     (bram_din),
      .bram_re      (bram_re),
      .bram_addrout (bram_addrout),
      .bram_dout    (bram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Block RAM with registered read address (write-first on same-address collisions).
   logic [DW-1:0] mem [256];
   logic [AW-1:0] raddr_q;
   always @(posedge clk) begin
      if (bram_we) mem[bram_addrin] <= bram_din;
      if (bram_re) raddr_q <= bram_addrout;
   end
   assign bram_dout = mem[raddr_q];

   // Reference state.
   logic [DW-1:0] ref_mem [256];
   int            pw;
   int            pr;
   logic [32:0]   q [$];
   int            n_vec;
   int            n_err;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference round-robin: scan backwards so the candidate nearest the pointer wins last.
   function automatic void rr_ref(input logic [1:0] req, input int ptr,
                                  output logic [1:0] g, output int idx);
      int c;
      g   = 2'b00;
      idx = 0;
      for (int k = 1; k >= 0; k--) begin
         c = (ptr + k) % 2;
         if (req[c]) begin
            g   = 2'b00;
            g[c] = 1'b1;
            idx = c;
         end
      end
   endfunction

   // One transaction cycle: check grants/RAM drive, update the model, cross the edge, check response.
   task automatic cycle();
      logic [1:0]  gw, gr;
      int          iw, ir;
      logic [32:0] e;
      #1;
      rr_ref(wr_req, pw, gw, iw);
      rr_ref(rd_req, pr, gr, ir);
      check_val("wr_gnt", 64'(wr_gnt), 64'(gw));
      check_val("rd_gnt", 64'(rd_gnt), 64'(gr));
      check_val("bram_we", 64'(bram_we), 64'(|gw));
      check_val("bram_re", 64'(bram_re), 64'(|gr));
      check_val("bram_addrin", 64'(bram_addrin), (|gw) ? 64'(wa[iw]) : 64'd0);
      check_val("bram_din", 64'(bram_din), (|gw) ? 64'(wd[iw]) : 64'd0);
      check_val("bram_addrout", 64'(bram_addrout), (|gr) ? 64'(ra[ir]) : 64'd0);
      if (|gw) begin
         ref_mem[wa[iw]] = wd[iw];
         pw = (iw + 1) % 2;
      end
      if (|gr) begin
         q.push_back({ir[0], ref_mem[ra[ir]]});
         pr = (ir + 1) % 2;
      end
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         check_val("rd_valid", 64'(rd_valid), 64'd1);
         check_val("rd_id", 64'(rd_id), 64'(e[32]));
         check_val("rd_data", 64'(rd_data), 64'(e[31:0]));
      end else begin
         check_val("rd_valid_idle", 64'(rd_valid), 64'd0);
      end
   endtask

   task automatic idle();
      wr_req = 2'b00;
      rd_req = 2'b00;
      cycle();
   endtask

   logic [1:0] rr_seq [4];

   initial begin
      n_vec = 0; n_err = 0; pw = 0; pr = 0;
      rst = 1'b1;
      wr_req = 2'b11; rd_req = 2'b11;
      wa[0] = 8'd0; wa[1] = 8'd0; wd[0] = 32'd0; wd[1] = 32'd0;
      ra[0] = 8'd0; ra[1] = 8'd0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;

      // Reset: grants forced low even with requests pending.
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_wr_gnt", 64'(wr_gnt), 64'd0);
      check_val("rst_rd_gnt", 64'(rd_gnt), 64'd0);
      check_val("rst_we", 64'(bram_we), 64'd0);
      check_val("rst_re", 64'(bram_re), 64'd0);
      check_val("rst_rd_valid", 64'(rd_valid), 64'd0);
      check_val("rst_rd_id", 64'(rd_id), 64'd0);
      wr_req = 2'b00; rd_req = 2'b00;
      rst = 1'b0;
      idle();

      // Round-robin on writes: W0 -> addr 3 = 0x33, W1 -> addr 4 = 0x44.
      rr_seq[0] = 2'b01; rr_seq[1] = 2'b10; rr_seq[2] = 2'b01; rr_seq[3] = 2'b10;
      wa[0] = 8'd3; wd[0] = 32'h33; wa[1] = 8'd4; wd[1] = 32'h44;
      wr_req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_val("rr_seq", 64'(wr_gnt), 64'(rr_seq[i]));
         @(negedge clk);
         cycle();
      end
      // W1 alone is granted every cycle; seed addr 7 = 0x1.
      wr_req = 2'b10; wa[1] = 8'd7; wd[1] = 32'h1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check_val("w1_only", 64'(wr_gnt), 64'h2);
         @(negedge clk);
         cycle();
      end

      // Single write then read from R1.
      wr_req = 2'b01; wa[0] = 8'd5; wd[0] = 32'hDEADBEEF;
      cycle();
      wr_req = 2'b00; rd_req = 2'b10; ra[1] = 8'd5;
      #1;
      check_val("r1_gnt", 64'(rd_gnt), 64'h2);
      @(negedge clk);
      cycle();
      idle();

      // Same-address write and read in one cycle returns the new word.
      wr_req = 2'b01; wa[0] = 8'd7; wd[0] = 32'h2;
      rd_req = 2'b01; ra[0] = 8'd7;
      cycle();
      check_val("wfirst_data", 64'(rd_data), 64'h2);
      idle();

      // Back-to-back reads from both requesters.
      wr_req = 2'b00; rd_req = 2'b11; ra[0] = 8'd3; ra[1] = 8'd4;
      repeat (4) cycle();
      idle();

      // Constrained random traffic over already-written addresses.
      for (int i = 0; i < 40; i++) begin
         wr_req = 2'($urandom_range(0, 3));
         rd_req = 2'($urandom_range(0, 3));
         for (int j = 0; j < 2; j++) begin
            case ($urandom_range(0, 3))
               0: wa[j] = 8'd3;
               1: wa[j] = 8'd4;
               2: wa[j] = 8'd5;
               default: wa[j] = 8'd7;
            endcase
            case ($urandom_range(0, 3))
               0: ra[j] = 8'd3;
               1: ra[j] = 8'd4;
               2: ra[j] = 8'd5;
               default: ra[j] = 8'd7;
            endcase
            wd[j] = $urandom;
         end
         cycle();
      end
      idle();

      // Reset between a read grant and its response cancels the response.
      wr_req = 2'b00; rd_req = 2'b01; ra[0] = 8'd3;
      #1;
      check_val("pre_rst_gnt", 64'(rd_gnt), 64'h1);
      rst = 1'b1;
      #1;
      check_val("mid_rst_gnt", 64'(rd_gnt), 64'd0);
      check_val("mid_rst_re", 64'(bram_re), 64'd0);
      @(posedge clk);
      #1;
      check_val("mid_rst_valid", 64'(rd_valid), 64'd0);
      rd_req = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      pw = 0; pr = 0;
      @(posedge clk);
      #1;
      check_val("post_rst_valid", 64'(rd_valid), 64'd0);
      wr_req = 2'b11; rd_req = 2'b11;
      wa[0] = 8'd9; wd[0] = 32'h99; wa[1] = 8'd10; wd[1] = 32'hAA;
      #1;
      check_val("post_rst_wgnt", 64'(wr_gnt), 64'h1);
      check_val("post_rst_rgnt", 64'(rd_gnt), 64'h1);
      @(negedge clk);
      cycle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
